// File: rtl/multi_4bits_pkg.sv
// Shared types and constants for the sequential 4-bit multiplier controller.
package multi_4bits_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Iteration counter width; keeps at least one bit for degenerate WIDTH=1
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/multi_4bits_seq_ctrl_if.sv
// Operand/product handshake bundle for multi_4bits_seq_ctrl.
// acc_clr only exists when MULTI_ACC_EN is defined.
interface multi_4bits_seq_ctrl_if #(
  parameter int WIDTH = multi_4bits_pkg::DEF_WIDTH
) ();

  logic [2*WIDTH-1:0] ui_in;
  logic               in_valid;
  logic               in_ready;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] uio_out;
  logic               busy;
`ifdef MULTI_ACC_EN
  logic               acc_clr;

  modport master (
    output ui_in, in_valid, out_ready, acc_clr,
    input  in_ready, out_valid, uio_out, busy
  );

  modport slave (
    input  ui_in, in_valid, out_ready, acc_clr,
    output in_ready, out_valid, uio_out, busy
  );
`else
  modport master (
    output ui_in, in_valid, out_ready,
    input  in_ready, out_valid, uio_out, busy
  );

  modport slave (
    input  ui_in, in_valid, out_ready,
    output in_ready, out_valid, uio_out, busy
  );
`endif

endinterface

// File: rtl/multi_4bits_shift_add.sv
// Datapath: operand registers, accumulator and bit counter for shift-and-add.
module multi_4bits_shift_add #(
  parameter int WIDTH = multi_4bits_pkg::DEF_WIDTH,
  parameter int CNT_W = multi_4bits_pkg::cnt_width(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               clr,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] acc,
  output logic [CNT_W-1:0]   count
);

  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [2*WIDTH-1:0] addend;

  assign addend = {{WIDTH{1'b0}}, a_reg} << count;

  // Accumulator wraps silently when chaining products in MAC mode
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      count <= '0;
    end else if (load) begin
      a_reg <= a;
      b_reg <= b;
      count <= '0;
      if (clr) acc <= '0;
    end else if (step) begin
      if (b_reg[count]) acc <= acc + addend;
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/multi_4bits_seq_ctrl.sv
// FSM and handshake control for the sequential shift-and-add multiplier.
// Optional MULTI_ACC_EN turns the accumulator into a MAC gated by acc_clr.
module multi_4bits_seq_ctrl #(
  parameter int WIDTH = multi_4bits_pkg::DEF_WIDTH
) (
  input logic                    clk,
  input logic                    rst_n,
  multi_4bits_seq_ctrl_if.slave  bus
);
  import multi_4bits_pkg::*;

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] count;
  logic             load;
  logic             step;
  logic             clr;

`ifdef MULTI_ACC_EN
  assign clr = bus.acc_clr;
`else
  assign clr = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // in_ready is low in DONE, so a new accept never overlaps the output handshake
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          load    = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        step = 1'b1;
        if (count == LAST) state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == CALC) || (state_q == DONE);

  multi_4bits_shift_add #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_shift_add (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .clr   (clr),
    .step  (step),
    .a     (bus.ui_in[WIDTH-1:0]),
    .b     (bus.ui_in[2*WIDTH-1:WIDTH]),
    .acc   (bus.uio_out),
    .count (count)
  );

endmodule

// File: tb/tb_multi_4bits_seq_ctrl.sv
// Directed bench for multi_4bits_seq_ctrl; MAC sequence runs when MULTI_ACC_EN is defined.
module tb_multi_4bits_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  multi_4bits_seq_ctrl_if #(.WIDTH(4)) bus ();

  multi_4bits_seq_ctrl #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    int         stall;
    logic [7:0] expected;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    check_output("wait_in_ready", int'(bus.in_ready), 1);
  endtask

  // Accept {b,a}, wait for the product, hold off out_ready for `stall` cycles, then take it
  task automatic apply_stimulus(input logic [3:0] a, input logic [3:0] b, input int stall,
                                output logic [7:0] product, output int lat);
    wait_ready();
    bus.ui_in    = {b, a};
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.ui_in    = 8'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    for (int i = 0; i < stall; i++) begin
      check_output("stall_out_valid", int'(bus.out_valid), 1);
      tick();
    end
    product       = bus.uio_out;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] product;
    int         lat;
    logic [7:0] pairs[4];
    logic [7:0] exp_q[4];

    vecs[0] = '{a: 4'd15, b: 4'd15, stall: 0, expected: 8'd225};
    vecs[1] = '{a: 4'd0,  b: 4'd13, stall: 1, expected: 8'd0};
    vecs[2] = '{a: 4'd11, b: 4'd0,  stall: 0, expected: 8'd0};
    vecs[3] = '{a: 4'd1,  b: 4'd1,  stall: 2, expected: 8'd1};
    vecs[4] = '{a: 4'd8,  b: 4'd8,  stall: 0, expected: 8'd64};
    vecs[5] = '{a: 4'd12, b: 4'd10, stall: 3, expected: 8'd120};
    vecs[6] = '{a: 4'd15, b: 4'd1,  stall: 0, expected: 8'd15};
    vecs[7] = '{a: 4'd5,  b: 4'd14, stall: 1, expected: 8'd70};

    rst_n         = 1'b0;
    bus.ui_in     = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
`ifdef MULTI_ACC_EN
    bus.acc_clr   = 1'b1;
`endif
    repeat (3) tick();
    check_output("rst_in_ready", int'(bus.in_ready), 1);
    check_output("rst_out_valid", int'(bus.out_valid), 0);
    check_output("rst_busy", int'(bus.busy), 0);
    check_output("rst_uio_out", int'(bus.uio_out), 0);
    rst_n = 1'b1;
    tick();

    $display("[TB] table vectors");
    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].a, vecs[i].b, vecs[i].stall, product, lat);
      check_output($sformatf("vec%0d_product", i), int'(product), int'(vecs[i].expected));
      check_output($sformatf("vec%0d_latency", i), lat, 4);
      check_output($sformatf("vec%0d_in_ready", i), int'(bus.in_ready), 1);
    end

    $display("[TB] exhaustive with random stalls");
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        apply_stimulus(4'(a), 4'(b), int'($urandom_range(0, 2)), product, lat);
        check_output($sformatf("exh_%0dx%0d", a, b), int'(product), a * b);
      end
    end

    $display("[TB] back-pressure 7*9");
    wait_ready();
    bus.ui_in    = {4'd9, 4'd7};
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check_output("bp_latency", lat, 4);
    for (int i = 0; i < 10; i++) begin
      check_output("bp_out_valid", int'(bus.out_valid), 1);
      check_output("bp_uio_out", int'(bus.uio_out), 63);
      check_output("bp_in_ready", int'(bus.in_ready), 0);
      bus.in_valid = (i % 2 == 0);
      bus.ui_in    = {4'd2, 4'd3};
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    tick();
    check_output("bp_idle_in_ready", int'(bus.in_ready), 1);
    check_output("bp_idle_busy", int'(bus.busy), 0);
    check_output("bp_idle_hold", int'(bus.uio_out), 63);

    $display("[TB] reset during CALC");
    wait_ready();
    bus.ui_in    = {4'd13, 4'd10};
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (2) tick();
    check_output("mid_busy", int'(bus.busy), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_output("abort_in_ready", int'(bus.in_ready), 1);
    check_output("abort_out_valid", int'(bus.out_valid), 0);
    check_output("abort_uio_out", int'(bus.uio_out), 0);
    apply_stimulus(4'd3, 4'd5, 0, product, lat);
    check_output("after_abort_product", int'(product), 15);

    $display("[TB] continuous in_valid");
    pairs = '{ {4'd2, 4'd3}, {4'd15, 4'd14}, {4'd0, 4'd9}, {4'd6, 4'd7} };
    exp_q = '{ 8'd6, 8'd210, 8'd0, 8'd42 };
    begin
      int cyc = 0;
      int idx = 0;
      int got = 0;
      int last_acc = -1;
      logic accepting;
      wait_ready();
      bus.ui_in     = pairs[0];
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      while (got < 4 && cyc < 100) begin
        accepting = bus.in_ready && bus.in_valid;
        if (bus.out_valid) begin
          check_output($sformatf("stream%0d_product", got), int'(bus.uio_out), int'(exp_q[got]));
          got++;
        end
        tick();
        cyc++;
        if (accepting) begin
          if (last_acc >= 0) check_output("stream_interval", cyc - last_acc, 6);
          last_acc = cyc;
          idx++;
          if (idx < 4) bus.ui_in = pairs[idx];
          else         bus.in_valid = 1'b0;
        end
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      check_output("stream_count", got, 4);
      check_output("stream_accepts", idx, 4);
    end

`ifdef MULTI_ACC_EN
    $display("[TB] MAC sequence");
    tick();
    bus.acc_clr = 1'b1;
    apply_stimulus(4'd3, 4'd4, 0, product, lat);
    check_output("mac_first", int'(product), 12);
    bus.acc_clr = 1'b0;
    apply_stimulus(4'd5, 4'd5, 1, product, lat);
    check_output("mac_second", int'(product), 37);
    apply_stimulus(4'd15, 4'd15, 0, product, lat);
    check_output("mac_wrap", int'(product), 6);
    bus.acc_clr = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
